// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared constants, state encoding and frame helper for the SPI transaction arbiter
package spi_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
  localparam logic [2:0] FRAME_BYTES       = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_XFER = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Frame layout: header, address, then write word little-endian.
  function automatic logic [7:0] frame_byte(input logic [7:0]  sync_byte,
                                            input logic [7:0]  addr,
                                            input logic [31:0] wdata,
                                            input logic [2:0]  idx);
    case (idx)
      3'd0:    frame_byte = sync_byte;
      3'd1:    frame_byte = addr;
      3'd2:    frame_byte = wdata[7:0];
      3'd3:    frame_byte = wdata[15:8];
      3'd4:    frame_byte = wdata[23:16];
      3'd5:    frame_byte = wdata[31:24];
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting the search at ptr
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter serialising register frames onto an SPI byte engine
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int         NREQ           = 3,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              m_ready,
  output logic [7:0]        m_tx_data,
  input  logic              m_valid,
  input  logic [7:0]        m_rx_data
);

  localparam int             IW       = $clog2(NREQ);
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: if (|req) state_d = ST_ARB;
      ST_ARB: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          addr_d  = req_addr[8*int'(arb_idx) +: 8];
          wdata_d = req_wdata[32*int'(arb_idx) +: 32];
          cnt_d   = '0;
          tmo_d   = '0;
          rdata_d = '0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (m_valid) begin
          cnt_d = cnt_q + 3'd1;
          // Data bytes arrive LSB first, so shift in from the top.
          if (cnt_q >= 3'd2) rdata_d = {m_rx_data, rdata_q[31:8]};
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q < FRAME_BYTES) begin
          tmo_d   = '0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign done      = (state_q == ST_DONE || state_q == ST_ERR) ? gnt_q : '0;
  assign err       = (state_q == ST_ERR);
  assign rdata     = (state_q == ST_ERR) ? 32'h0 : rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign m_ready   = (state_q == ST_XFER);
  assign m_tx_data = (state_q == ST_XFER) ? frame_byte(SYNC_BYTE, addr_q, wdata_q, cnt_q) : 8'h00;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_addr = '0;
  logic [95:0] req_wdata = '0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic        m_ready;
  logic [7:0]  m_tx_data;
  logic        m_valid;
  logic [7:0]  m_rx_data = '0;
  logic        eng_en = 1'b0;

  assign m_valid = eng_en;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(16), .SYNC_BYTE(8'h5A)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .m_ready   (m_ready),
    .m_tx_data (m_tx_data),
    .m_valid   (m_valid),
    .m_rx_data (m_rx_data)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          tx_n = 0;
  int          frame_start = 0;
  int          onehot_viol = 0;
  int          done_cnt [3];
  logic [7:0]  tx_log [256];
  logic [7:0]  rx_tab [6];
  logic [7:0]  exp_b [6];

  logic [2:0]  d_s;
  logic        e_s;
  logic [31:0] rd_s;
  logic [2:0]  g_s;
  logic        mr_s;
  int          lat;
  int          dc_snap [3];
  logic [2:0]  expv;

  initial begin
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
  end

  always @(posedge clk) cyc++;

  // Byte engine model plus passive bookkeeping, evaluated mid-cycle.
  always @(negedge clk) begin
    if (m_ready && m_valid) begin
      m_rx_data = rx_tab[(tx_n - frame_start) % 6];
      tx_log[tx_n % 256] = m_tx_data;
      tx_n++;
    end
    if ($countones(gnt) > 1) onehot_viol++;
    for (int i = 0; i < 3; i++) if (done[i]) done_cnt[i]++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int l);
    int  c0;
    bit  hit;
    c0  = cyc;
    hit = 1'b0;
    l   = -1;
    d_s = '0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      if (done != 3'b000) begin
        hit  = 1'b1;
        d_s  = done;
        e_s  = err;
        rd_s = rdata;
        g_s  = gnt;
        mr_s = m_ready;
        l    = cyc - c0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) rx_tab[i] = 8'h00;
    repeat (3) tick();
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    check_val("rst_err", 32'(err), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_m_ready", 32'(m_ready), 32'h0);
    check_val("rst_m_tx_data", 32'(m_tx_data), 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    tick();
    check_val("idle_busy", 32'(busy), 32'h0);

    // Single write from requester 0, zero-wait engine.
    eng_en = 1'b1;
    req_addr[7:0]   = 8'h21;
    req_wdata[31:0] = 32'h12345678;
    frame_start = tx_n;
    req = 3'b001;
    tick();
    check_val("arb_busy", 32'(busy), 32'h1);
    check_val("arb_gnt", 32'(gnt), 32'h0);
    wait_done(40, lat);
    req = 3'b000;
    check_val("wr_latency", 32'(lat), 32'd13);
    check_val("wr_done", 32'(d_s), 32'h1);
    check_val("wr_gnt", 32'(g_s), 32'h1);
    check_val("wr_err", 32'(e_s), 32'h0);
    check_val("wr_nbytes", 32'(tx_n - frame_start), 32'd6);
    exp_b[0] = 8'h5A; exp_b[1] = 8'h21; exp_b[2] = 8'h78;
    exp_b[3] = 8'h56; exp_b[4] = 8'h34; exp_b[5] = 8'h12;
    for (int i = 0; i < 6; i++) check_val("wr_txbyte", 32'(tx_log[(frame_start + i) % 256]), 32'(exp_b[i]));
    tick();
    check_val("post_busy", 32'(busy), 32'h0);
    check_val("post_gnt", 32'(gnt), 32'h0);
    check_val("post_done", 32'(done), 32'h0);

    // Readback through requester 1.
    rx_tab[0] = 8'hAA; rx_tab[1] = 8'hBB; rx_tab[2] = 8'h11;
    rx_tab[3] = 8'h22; rx_tab[4] = 8'h33; rx_tab[5] = 8'h44;
    req_addr[15:8]   = 8'h40;
    req_wdata[63:32] = 32'hCAFE0001;
    frame_start = tx_n;
    req = 3'b010;
    tick();
    wait_done(40, lat);
    req = 3'b000;
    check_val("rd_latency", 32'(lat), 32'd13);
    check_val("rd_done", 32'(d_s), 32'h2);
    check_val("rd_rdata", rd_s, 32'h44332211);
    check_val("rd_err", 32'(e_s), 32'h0);
    check_val("rd_tx_addr", 32'(tx_log[(frame_start + 1) % 256]), 32'h40);
    check_val("rd_tx_w0", 32'(tx_log[(frame_start + 2) % 256]), 32'h01);
    check_val("rd_tx_w3", 32'(tx_log[(frame_start + 5) % 256]), 32'hCA);
    tick();

    // Round robin from a fresh reset with all three requesting.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) dc_snap[i] = done_cnt[i];
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      expv = 3'b001 << k;
      wait_done(40, lat);
      check_val("rr_order", 32'(d_s), 32'(expv));
      req = req & ~d_s;
    end
    req = 3'b000;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) check_val("rr_done_once", 32'(done_cnt[i] - dc_snap[i]), 32'd1);
    check_val("rr_idle", 32'(busy), 32'h0);

    // Requester 1 drops its request right after being granted.
    frame_start = tx_n;
    req = 3'b010;
    for (int i = 0; i < 6 && gnt == 3'b000; i++) tick();
    check_val("drop_gnt", 32'(gnt), 32'h2);
    req = 3'b000;
    wait_done(40, lat);
    check_val("drop_done", 32'(d_s), 32'h2);
    check_val("drop_nbytes", 32'(tx_n - frame_start), 32'd6);
    tick();

    // Reset in the middle of byte 3.
    frame_start = tx_n;
    req = 3'b100;
    for (int i = 0; i < 40 && (tx_n - frame_start) < 4; i++) tick();
    check_val("mid_gnt", 32'(gnt), 32'h4);
    for (int i = 0; i < 3; i++) dc_snap[i] = done_cnt[i];
    rstn = 1'b0;
    req  = 3'b000;
    #1;
    check_val("arst_gnt", 32'(gnt), 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    check_val("arst_m_ready", 32'(m_ready), 32'h0);
    check_val("arst_m_tx_data", 32'(m_tx_data), 32'h0);
    check_val("arst_done", 32'(done), 32'h0);
    check_val("arst_err", 32'(err), 32'h0);
    repeat (3) tick();
    check_val("arst_no_done", 32'(done_cnt[2] - dc_snap[2]), 32'd0);
    rstn = 1'b1;
    frame_start = tx_n;
    req = 3'b111;
    tick();
    tick();
    check_val("restart_gnt", 32'(gnt), 32'h1);
    check_val("restart_m_ready", 32'(m_ready), 32'h1);
    check_val("restart_sync", 32'(m_tx_data), 32'h5A);
    wait_done(40, lat);
    req = 3'b000;
    check_val("restart_done", 32'(d_s), 32'h1);
    tick();

    // Engine stalls forever: frame aborts after the timeout.
    eng_en = 1'b0;
    req = 3'b001;
    tick();
    wait_done(40, lat);
    req = 3'b000;
    check_val("tmo_latency", 32'(lat), 32'd17);
    check_val("tmo_err", 32'(e_s), 32'h1);
    check_val("tmo_done", 32'(d_s), 32'h1);
    check_val("tmo_m_ready", 32'(mr_s), 32'h0);
    check_val("tmo_rdata", rd_s, 32'h0);
    tick();
    check_val("tmo_idle", 32'(busy), 32'h0);
    check_val("tmo_err_clear", 32'(err), 32'h0);

    check_val("gnt_onehot", 32'(onehot_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles per byte handshake before abort.
REQ-003 Parameter SYNC_BYTE, default 8'h5A, frame header byte.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester transaction request, level, held until done.
REQ-007 req_addr  input  NREQ*8  per-requester register address, slice i = bits [8i+7:8i].
REQ-008 req_wdata  input  NREQ*32  per-requester write word, slice i = bits [32i+31:32i].
REQ-009 gnt  output  NREQ  one-hot grant, at most one bit set.
REQ-010 done  output  NREQ  one-cycle completion pulse to granted requester.
REQ-011 err  output  1  one-cycle pulse, coincident with done, when the transaction aborted on timeout.
REQ-012 rdata  output  32  word shifted in during data bytes, valid in the done cycle.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 m_ready  output  1  byte-start/tx-valid to the SPI master byte engine.
REQ-015 m_tx_data  output  8  byte to transmit, stable while m_ready high.
REQ-016 m_valid  input  1  byte-complete from the SPI master byte engine.
REQ-017 m_rx_data  input  8  received byte, valid with m_valid.

Function
REQ-018 Frame: 6 bytes in order SYNC_BYTE, addr, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24].
REQ-019 States: IDLE, ARB, XFER, GAP, DONE, ERR.
REQ-020 IDLE: any req bit high -> ARB next cycle; else stay.
REQ-021 ARB: round-robin choice, search starts at last-granted index + 1 mod NREQ (index 0 after reset); set gnt, latch addr/wdata, clear byte counter and rdata, -> XFER.
REQ-022 ARB with all req low (dropped in the IDLE->ARB cycle): no grant, return to IDLE.
REQ-023 XFER: m_ready high, m_tx_data = frame byte[byte counter]; byte completes on the clk edge where m_valid && m_ready.
REQ-024 On byte completion: m_ready low next cycle, byte counter +1, -> GAP; bytes 2..5 shift m_rx_data into rdata LSB-byte first (byte 2 -> rdata[7:0]).
REQ-025 GAP: exactly one cycle with m_ready low; -> XFER if counter < 6, else DONE.
REQ-026 DONE: done[granted] = 1 and gnt held for this single cycle; update last-granted pointer; -> IDLE.
REQ-027 Timeout counter clears on XFER entry; in XFER, counter reaching TIMEOUT_CYCLES without completion -> ERR.
REQ-028 ERR: m_ready low, err = 1, done[granted] = 1, rdata = 0 for one cycle; pointer updates; -> IDLE.
REQ-029 Requester dropping req after grant does not abort; frame completes and done still pulses.
REQ-030 m_valid while m_ready low is ignored.
REQ-031 Minimum frame latency: ARB entry to done = 1 + 6*(handshake + GAP) cycles; zero-wait engine gives 13 cycles.

Reset
REQ-032 rstn low asynchronously forces IDLE, gnt/done/err/m_ready = 0, m_tx_data = 8'h00, rdata = 0, busy = 0, pointer = 0, counters = 0.
REQ-033 Reset mid-frame abandons the frame with no done or err pulse.

Structure
REQ-034 Package spi_ctrl_pkg holds SYNC_BYTE default, FRAME_BYTES = 6, state encoding constants.
REQ-035 One sub-module rr_arbiter: combinational round-robin picker (req, pointer -> one-hot grant, index).

Verification
REQ-036 Single write: req[0], addr 8'h21, wdata 32'h12345678, zero-wait engine -> tx bytes 5A,21,78,56,34,12; done[0] 13 cycles after ARB.
REQ-037 Simultaneous req = 3'b111 after reset, held until own done -> grant order 0,1,2; each exactly one done.
REQ-038 Readback: engine returns AA,BB,11,22,33,44 -> rdata = 32'h44332211 in done cycle.
REQ-039 Timeout: TIMEOUT_CYCLES = 16, engine never asserts m_valid -> err and done[granted] 16 cycles after XFER entry, m_ready low, then IDLE.
REQ-040 rstn low during byte 3 -> all outputs 0 immediately; no done; next req restarts at SYNC_BYTE with grant to index 0.
REQ-041 req[1] dropped after gnt[1] -> full 6-byte frame still sent, done[1] pulses.
